key_debouncer: RTL

Conditions the 16 raw key inputs from the board (push-buttons, switches, tile sensors) before they reach the tone player and game logic. Each input is synchronized to `CLOCK_50`, filtered so that only a level held for a programmable number of sample periods is accepted, and presented as a clean active-high `keys[15:0]` bus. Alongside the bus, the block emits one-cycle press and release event pulses for the game scoring logic.

---
 rtl/key_pkg.sv | 42 ++++
 rtl/key_debouncer_debounce_cell.sv | 78 +++++++
 rtl/key_debouncer.sv | 89 ++++++++
 3 files changed

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared constants for the key input path: the channel count, the key-index
// map used by the tone player and game logic, and small width helpers used
// by the debouncer when sizing its counters.
// ---------------------------------------------------------------------------
package key_pkg;

    localparam int N_KEYS = 16;

    // Note keys, in the order the tone player expects them
    localparam int KEY_C  = 0;
    localparam int KEY_CS = 1;
    localparam int KEY_D  = 2;
    localparam int KEY_DS = 3;
    localparam int KEY_E  = 4;
    localparam int KEY_F  = 5;
    localparam int KEY_FS = 6;
    localparam int KEY_G  = 7;
    localparam int KEY_GS = 8;
    localparam int KEY_A  = 9;
    localparam int KEY_AS = 10;
    localparam int KEY_B  = 11;

    // Game control inputs
    localparam int KEY_CTRL0 = 12;
    localparam int KEY_CTRL1 = 13;
    localparam int KEY_CTRL2 = 14;
    localparam int KEY_CTRL3 = 15;

    // Differing-sample counter width; never narrower than one bit, even
    // when a single sample is enough to accept a change.
    function automatic int cnt_width(input int stable_samples);
        return (stable_samples < 2) ? 1 : $clog2(stable_samples);
    endfunction

    // Prescaler width for a divide-by-div counter (div is at least 2).
    function automatic int prescale_width(input int div);
        return $clog2(div);
    endfunction

endpackage

// File: rtl/key_debouncer_debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
// One debounced key channel. On each sample tick the synchronized input is
// compared with the accepted level; only a run of STABLE_SAMPLES
// consecutive differing samples flips the level. The flip is reported with
// a one-cycle rise or fall pulse, registered alongside the level.
//
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset
//   s     in   synchronized (and polarity-corrected) key level
//   tick  in   one-cycle sample strobe from the shared prescaler
//   level out  accepted key level
//   rise  out  one-cycle pulse when level goes 0 -> 1
//   fall  out  one-cycle pulse when level goes 1 -> 0
// ---------------------------------------------------------------------------
module debounce_cell
    import key_pkg::*;
#(
    parameter int STABLE_SAMPLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              CW       = cnt_width(STABLE_SAMPLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_SAMPLES - 1);

    logic          level_q, level_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;

    // Any sample that agrees with the accepted level restarts the count, so
    // a bounce shorter than the window never reaches CNT_LAST.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick) begin
            if (s == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                level_d = s;
                cnt_d   = '0;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// Conditions the raw board key inputs: a two-flop synchronizer per bit, an
// optional polarity inversion, one shared sample-rate prescaler and one
// debounce_cell per key. Produces clean active-high levels plus one-cycle
// press/release pulses, and an any-key flag.
//
// Ports:
//   CLOCK_50  in   system clock
//   reset     in   asynchronous active-high reset
//   raw_keys  in   [N_KEYS] asynchronous raw key levels
//   keys      out  [N_KEYS] debounced levels, active-high
//   key_down  out  [N_KEYS] one-cycle pulse when keys[i] rises
//   key_up    out  [N_KEYS] one-cycle pulse when keys[i] falls
//   any_key   out  OR of the registered keys
// ---------------------------------------------------------------------------
module key_debouncer #(
    parameter int N_KEYS         = key_pkg::N_KEYS,
    parameter int CLK_HZ         = 50_000_000,
    parameter int SAMPLE_HZ      = 1000,
    parameter int STABLE_SAMPLES = 8,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] raw_keys,
    output logic [N_KEYS-1:0] keys,
    output logic [N_KEYS-1:0] key_down,
    output logic [N_KEYS-1:0] key_up,
    output logic              any_key
);

    import key_pkg::*;

    localparam int                DIV      = CLK_HZ / SAMPLE_HZ;
    localparam int                PW       = prescale_width(DIV);
    localparam logic [PW-1:0]     PRE_LAST = PW'(DIV - 1);
    localparam logic [N_KEYS-1:0] IDLE_RAW = {N_KEYS{ACTIVE_LOW}};

    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [PW-1:0]     pre_q,   pre_d;
    logic              tick;
    logic [N_KEYS-1:0] s;

    // Synchronizer chain and free-running prescaler. The prescaler wraps at
    // DIV-1, so tick is a single-cycle strobe every DIV clocks.
    always_comb begin
        sync1_d = raw_keys;
        sync2_d = sync1_q;
        pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end

    // The chain resets to the idle raw level so that an active-low board
    // does not see a phantom press while the chain refills after reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_q <= IDLE_RAW;
            sync2_q <= IDLE_RAW;
            pre_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            pre_q   <= pre_d;
        end
    end

    assign tick = (pre_q == PRE_LAST);
    assign s    = ACTIVE_LOW ? ~sync2_q : sync2_q;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_cell
        debounce_cell #(
            .STABLE_SAMPLES (STABLE_SAMPLES)
        ) u_cell (
            .clk   (CLOCK_50),
            .rst   (reset),
            .s     (s[i]),
            .tick  (tick),
            .level (keys[i]),
            .rise  (key_down[i]),
            .fall  (key_up[i])
        );
    end

    // Derived from the registered levels so it changes in the same cycle
    // as keys without adding another register stage.
    assign any_key = |keys;

endmodule
